// File: rtl/dsp48a1_pkg.sv
// Shared widths, operand-select codes and OPMODE bit positions for the DSP48A1 slice model.
package dsp48a1_pkg;

   localparam int unsigned P_W      = 48;
   localparam int unsigned M_W      = 36;
   localparam int unsigned AB_W     = 18;
   localparam int unsigned D_USED_W = 12;

   localparam int unsigned OPM_SUB = 7;
   localparam int unsigned OPM_CIN = 5;

   typedef enum logic [1:0] {
      X_ZERO = 2'd0,
      X_M    = 2'd1,
      X_P    = 2'd2,
      X_DAB  = 2'd3
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'd0,
      Z_PCIN = 2'd1,
      Z_P    = 2'd2,
      Z_C    = 2'd3
   } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Parameterised pipeline register: optional (REG=0 gives a wire), reset beats clock enable.
module dsp_pipe_reg #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned REG     = 1,
   parameter string       RSTTYPE = "sync"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (REG == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ rst ^ ce;
      assign q = d;
   end else if (RSTTYPE == "sync") begin : g_sync
      logic [WIDTH-1:0] q_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            q_q <= '0;
         end else if (ce) begin
            q_q <= d;
         end
      end
      assign q = q_q;
   end else if (RSTTYPE == "async") begin : g_async
      logic [WIDTH-1:0] q_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q_q <= '0;
         end else if (ce) begin
            q_q <= d;
         end
      end
      assign q = q_q;
   end else begin : g_bad_rsttype
      $error("dsp_pipe_reg: RSTTYPE must be \"sync\" or \"async\"");
   end

endmodule

// File: rtl/dsp_xz_mux.sv
// Combinational X and Z operand selection for the post-adder.
module dsp_xz_mux
   import dsp48a1_pkg::*;
(
   input  x_sel_e              x_sel,
   input  z_sel_e              z_sel,
   input  logic [M_W-1:0]      m,
   input  logic [P_W-1:0]      p_fb,
   input  logic [D_USED_W-1:0] d,
   input  logic [AB_W-1:0]     a,
   input  logic [AB_W-1:0]     b,
   input  logic [P_W-1:0]      pcin,
   input  logic [P_W-1:0]      c,
   output logic [P_W-1:0]      x,
   output logic [P_W-1:0]      z
);

   always_comb begin
      x = '0;
      unique case (x_sel)
         X_ZERO:  x = '0;
         X_M:     x = {{(P_W - M_W){1'b0}}, m};
         X_P:     x = p_fb;
         X_DAB:   x = {d, a, b};
         default: x = '0;
      endcase
   end

   always_comb begin
      z = '0;
      unique case (z_sel)
         Z_ZERO:  z = '0;
         Z_PCIN:  z = pcin;
         Z_P:     z = p_fb;
         Z_C:     z = c;
         default: z = '0;
      endcase
   end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-selected X/Z operands, add or subtract with carry-in,
// registered 48-bit P with carry-out and P feedback for multiply-accumulate.
module dsp_post_adder_acc
   import dsp48a1_pkg::*;
#(
   parameter int unsigned PREG        = 1,
   parameter int unsigned CARRYOUTREG = 1,
   parameter int unsigned OPMODEREG   = 1,
   parameter int unsigned CARRYINREG  = 1,
   parameter string       CARRYINSEL  = "OPMODE5"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_opmode,
   input  logic             ce_carryin,
   input  logic             ce_p,
   input  logic [7:0]       opmode,
   input  logic             carryin,
   input  logic [M_W-1:0]   m,
   input  logic [P_W-1:0]   c,
   input  logic [AB_W-1:0]  d,
   input  logic [AB_W-1:0]  a,
   input  logic [AB_W-1:0]  b,
   input  logic [P_W-1:0]   pcin,
   output logic [P_W-1:0]   p,
   output logic [P_W-1:0]   pcout,
   output logic             carryout,
   output logic             carryoutf
);

   // Only the bits that reach the adder are staged: {sub, z_sel, x_sel}.
   logic [4:0]   opm_in, opm_q;
   logic         cin_sel, cin_q;
   logic [P_W-1:0] x, z, p_fb, p_q;
   logic [P_W:0]   sum;
   logic           cout_q;

   logic unused_bits;
   assign unused_bits = ^{opmode[6], opmode[4], opmode[OPM_CIN], carryin, d[AB_W-1:D_USED_W]};

   assign opm_in = {opmode[OPM_SUB], opmode[3:0]};

   if (CARRYINSEL == "OPMODE5") begin : g_cin_opm
      assign cin_sel = opmode[OPM_CIN];
   end else if (CARRYINSEL == "CARRYIN") begin : g_cin_ext
      assign cin_sel = carryin;
   end else begin : g_cin_bad
      assign cin_sel = 1'b0;
      $error("dsp_post_adder_acc: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
   end

   dsp_pipe_reg #(.WIDTH(5), .REG(OPMODEREG), .RSTTYPE("sync")) u_opmode_reg (
      .clk (clk),
      .rst (rst),
      .ce  (ce_opmode),
      .d   (opm_in),
      .q   (opm_q)
   );

   dsp_pipe_reg #(.WIDTH(1), .REG(CARRYINREG), .RSTTYPE("sync")) u_carryin_reg (
      .clk (clk),
      .rst (rst),
      .ce  (ce_carryin),
      .d   (cin_sel),
      .q   (cin_q)
   );

   // Without a P register the feedback operand is grounded so no combinational loop forms.
   if (PREG != 0) begin : g_fb
      assign p_fb = p_q;
   end else begin : g_no_fb
      assign p_fb = '0;
   end

   dsp_xz_mux u_xz_mux (
      .x_sel (x_sel_e'(opm_q[1:0])),
      .z_sel (z_sel_e'(opm_q[3:2])),
      .m     (m),
      .p_fb  (p_fb),
      .d     (d[D_USED_W-1:0]),
      .a     (a),
      .b     (b),
      .pcin  (pcin),
      .c     (c),
      .x     (x),
      .z     (z)
   );

   always_comb begin
      sum = '0;
      if (opm_q[4]) begin
         sum = {1'b0, z} - {1'b0, x} - {{P_W{1'b0}}, cin_q};
      end else begin
         sum = {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, cin_q};
      end
   end

   dsp_pipe_reg #(.WIDTH(P_W), .REG(PREG), .RSTTYPE("sync")) u_p_reg (
      .clk (clk),
      .rst (rst),
      .ce  (ce_p),
      .d   (sum[P_W-1:0]),
      .q   (p_q)
   );

   dsp_pipe_reg #(.WIDTH(1), .REG(CARRYOUTREG), .RSTTYPE("sync")) u_carryout_reg (
      .clk (clk),
      .rst (rst),
      .ce  (ce_p),
      .d   (sum[P_W]),
      .q   (cout_q)
   );

   assign p         = p_q;
   assign pcout     = p_q;
   assign carryout  = cout_q;
   assign carryoutf = cout_q;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scoreboard bench: stimulus queues hand-computed results tagged with the edge they must appear
// after; a monitor pops and compares them. A second instance covers the combinational variant.
module tb_dsp_post_adder_acc;

   typedef struct {
      int          at;
      logic [47:0] p;
      logic        co;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_opmode = 1'b1, ce_carryin = 1'b1, ce_p = 1'b1;
   logic [7:0]  opmode = '0;
   logic        carryin = 1'b0;
   logic [35:0] m = '0;
   logic [47:0] c = '0, pcin = '0;
   logic [17:0] d = '0, a = '0, b = '0;
   logic [47:0] p, pcout;
   logic        carryout, carryoutf;

   logic [7:0]  opmode2 = '0;
   logic        carryin2 = 1'b0;
   logic [35:0] m2 = '0;
   logic [47:0] c2 = '0, pcin2 = '0;
   logic [17:0] d2 = '0, a2 = '0, b2 = '0;
   logic [47:0] p2, pcout2;
   logic        carryout2, carryoutf2;

   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t sb2[$];
   exp_t e_mon;

   always #5 clk = ~clk;

   dsp_post_adder_acc dut (
      .clk        (clk),
      .rst        (rst),
      .ce_opmode  (ce_opmode),
      .ce_carryin (ce_carryin),
      .ce_p       (ce_p),
      .opmode     (opmode),
      .carryin    (carryin),
      .m          (m),
      .c          (c),
      .d          (d),
      .a          (a),
      .b          (b),
      .pcin       (pcin),
      .p          (p),
      .pcout      (pcout),
      .carryout   (carryout),
      .carryoutf  (carryoutf)
   );

   dsp_post_adder_acc #(
      .PREG       (0),
      .OPMODEREG  (0),
      .CARRYINREG (0),
      .CARRYINSEL ("CARRYIN")
   ) dut_comb (
      .clk        (clk),
      .rst        (rst),
      .ce_opmode  (ce_opmode),
      .ce_carryin (ce_carryin),
      .ce_p       (ce_p),
      .opmode     (opmode2),
      .carryin    (carryin2),
      .m          (m2),
      .c          (c2),
      .d          (d2),
      .a          (a2),
      .b          (b2),
      .pcin       (pcin2),
      .p          (p2),
      .pcout      (pcout2),
      .carryout   (carryout2),
      .carryoutf  (carryoutf2)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      edge_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
         e_mon = sb.pop_front();
         chk({e_mon.tag, ".p"}, p, e_mon.p);
         chk({e_mon.tag, ".pcout"}, pcout, e_mon.p);
         chk({e_mon.tag, ".carryout"}, {47'b0, carryout}, {47'b0, e_mon.co});
         chk({e_mon.tag, ".carryoutf"}, {47'b0, carryoutf}, {47'b0, e_mon.co});
      end
      while (sb2.size() > 0 && sb2[0].at <= edge_cnt) begin
         e_mon = sb2.pop_front();
         chk({e_mon.tag, ".p"}, p2, e_mon.p);
         chk({e_mon.tag, ".pcout"}, pcout2, e_mon.p);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic exp1(input int k, input logic [47:0] pv, input logic co, input string tag);
      sb.push_back('{edge_cnt + k, pv, co, tag});
   endtask

   task automatic exp2(input logic [47:0] pv, input string tag);
      sb2.push_back('{edge_cnt + 1, pv, 1'b0, tag});
   endtask

   initial begin
      tick();
      exp1(1, 48'd0, 1'b0, "reset0");
      tick();
      exp1(1, 48'd0, 1'b0, "reset1");
      tick();

      // Plain add: opmode presented one cycle ahead of the result it controls.
      rst = 1'b0; opmode = 8'h0D; m = 36'd100; c = 48'd5;
      exp1(1, 48'd0, 1'b0, "add_opm_lag");
      exp1(2, 48'd105, 1'b0, "add");
      tick(); tick();

      opmode = 8'hAD; c = 48'd10; m = 36'd4;
      exp1(1, 48'd14, 1'b0, "sub_prev_add");
      exp1(2, 48'd5, 1'b0, "sub_cin");
      tick(); tick();
      c = 48'd0; m = 36'd0;
      exp1(1, 48'hFFFF_FFFF_FFFF, 1'b1, "sub_borrow");
      tick();

      opmode = 8'h0D; c = 48'hFFFF_FFFF_FFFF; m = 36'd1;
      exp1(1, 48'hFFFF_FFFF_FFFD, 1'b0, "sub_big");
      exp1(2, 48'd0, 1'b1, "wrap");
      tick(); tick();

      // MAC from reset; registered opmode is also cleared, so one zero result first.
      rst = 1'b1; opmode = 8'h09; m = 36'd3; c = 48'd0;
      exp1(1, 48'd0, 1'b0, "mac_rst");
      tick();
      rst = 1'b0;
      exp1(1, 48'd0, 1'b0, "mac_opm_lag");
      tick();
      for (int i = 1; i <= 4; i++) begin
         exp1(1, 48'(3 * i), 1'b0, "mac");
         tick();
      end
      ce_p = 1'b0;
      exp1(1, 48'd12, 1'b0, "mac_hold");
      tick();
      ce_p = 1'b1;
      exp1(1, 48'd15, 1'b0, "mac_resume");
      tick();
      rst = 1'b1;
      exp1(1, 48'd0, 1'b0, "mid_rst");
      tick();
      rst = 1'b0;
      exp1(1, 48'd0, 1'b0, "post_rst_lag");
      tick();
      exp1(1, 48'd3, 1'b0, "post_rst_acc1");
      tick();
      exp1(1, 48'd6, 1'b0, "post_rst_acc2");
      tick();

      // Held OPMODE register keeps accumulating despite a new opmode on the pins.
      ce_opmode = 1'b0; opmode = 8'h0D; c = 48'd100;
      exp1(1, 48'd9, 1'b0, "opm_hold1");
      tick();
      exp1(1, 48'd12, 1'b0, "opm_hold2");
      tick();
      ce_opmode = 1'b1;
      exp1(1, 48'd15, 1'b0, "opm_release");
      exp1(2, 48'd103, 1'b0, "opm_new");
      tick(); tick();

      opmode = 8'h07; d = 18'h3F001; a = 18'd2; b = 18'd3; pcin = 48'd10;
      exp1(1, 48'd103, 1'b0, "dab_lag");
      exp1(2, 48'h0010_0008_000D, 1'b0, "dab_pcin");
      tick(); tick();

      // Combinational variant: result visible in the same cycle, external carry-in.
      opmode2 = 8'h23; d2 = 18'h3F001;
      exp2(48'h0010_0000_0000, "comb_dab");
      tick();
      carryin2 = 1'b1;
      exp2(48'h0010_0000_0001, "comb_cin");
      tick();
      carryin2 = 1'b0; opmode2 = 8'h83;
      exp2(48'hFFF0_0000_0000, "comb_sub");
      tick();
      opmode2 = 8'h0F; c2 = 48'd5; carryin2 = 1'b1; d2 = 18'd0; a2 = 18'd1; b2 = 18'd2;
      exp2(48'h0000_0004_0008, "comb_c_dab");
      tick();
      opmode2 = 8'h0A; carryin2 = 1'b0;
      exp2(48'd0, "comb_no_fb");
      tick();

      for (int i = 0; i < 20 && (sb.size() > 0 || sb2.size() > 0); i++) tick();
      if (sb.size() > 0 || sb2.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending, required 0", sb.size() + sb2.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_post_adder_acc.md
# dsp_post_adder_acc

Post-adder/accumulator stage of the DSP48A1 slice model, directly downstream of the M (multiplier) pipeline register and C register. Selects X and Z operands under OPMODE control, adds or subtracts them with a selectable carry-in, and registers the 48-bit result (P) and carry-out. P feedback gives a multiply-accumulate path, and PCOUT feeds the next slice's PCIN.

## Interface
Parameters:
- PREG, 1, 1 = P register present; 0 = P combinational.
- CARRYOUTREG, 1, 1 = CARRYOUT registered; 0 = combinational.
- OPMODEREG, 1, 1 = OPMODE captured in a register before use.
- CARRYINREG, 1, 1 = selected carry-in captured in a register before use.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" or "CARRYIN".

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous, active-high; clears every register in the block.
- ce_opmode, in, 1, enable for the OPMODE register.
- ce_carryin, in, 1, enable for the carry-in register.
- ce_p, in, 1, enable for the P and CARRYOUT registers.
- opmode, in, 8, uses bits [7], [5] and [3:0]; bits [6] and [4] are ignored here.
- carryin, in, 1, external carry-in.
- m, in, 36, M-register product.
- c, in, 48, C-register value.
- d, in, 18, D-register value; only bits [11:0] are used.
- a, in, 18, A1-register value.
- b, in, 18, B1-register value.
- pcin, in, 48, cascade input from the previous slice.
- p, out, 48, result.
- pcout, out, 48, always equal to p.
- carryout, out, 1, bit 48 of the 49-bit result.
- carryoutf, out, 1, always equal to carryout.

## Operation
- X mux, selected by opmode[1:0]:
  - 0: zero.
  - 1: m, zero-extended to 48 bits.
  - 2: current P register value.
  - 3: {d[11:0], a, b}.
- Z mux, selected by opmode[3:2]:
  - 0: zero.
  - 1: pcin.
  - 2: current P register value.
  - 3: c.
- Carry-in source is opmode[5] when CARRYINSEL="OPMODE5", and carryin when CARRYINSEL="CARRYIN". Any other CARRYINSEL string is an elaboration error.
- Arithmetic is 49-bit unsigned two's-complement:
  - opmode[7]=0: {cout, sum} = Z + X + cin.
  - opmode[7]=1: {cout, sum} = Z − (X + cin).
  - Wrap-around is modulo 2^49, with no saturation.
- P feedback (either mux selecting 2) is legal only with PREG=1. With PREG=0 the feedback input is tied to 0, so no combinational loop exists.
- Register rules, common to all four registers (OPMODE, carry-in, P, CARRYOUT):
  - rst has priority over ce.
  - ce low holds the current value.
  - With the *REG parameter = 0, the register is replaced by a wire.
- Reset value of every output: p=0, pcout=0, carryout=0, carryoutf=0. With PREG=0 or CARRYOUTREG=0 the outputs follow the combinational result during reset.
- Reset mid-accumulation: P=0 after the reset edge, and the next enabled cycle with X=P accumulates from 0.
- ce_p low during accumulation freezes P. The feedback operand stays at the frozen value.

## Timing
- Data latency (m/c/dab/pcin to p) is PREG cycles: with PREG=1, inputs sampled at edge N appear on p after edge N.
- OPMODE and carry-in latency to p is OPMODEREG+PREG and CARRYINREG+PREG respectively. Upstream presents opmode one cycle early when OPMODEREG=1.
- carryout latency is CARRYOUTREG cycles from the same sum. It is aligned with p when CARRYOUTREG=PREG.
- Simultaneous rst and any ce: reset wins.
- Simultaneous opmode change and data arrival: the registered opmode applies to the data present at its use cycle; there is no bypass.
- Accumulate (X=m, Z=P) sustains one result per cycle with no bubbles.

## Structure
- Shared package dsp48a1_pkg holds:
  - widths P_W=48, M_W=36, AB_W=18, D_USED_W=12.
  - X select codes X_ZERO/X_M/X_P/X_DAB.
  - Z select codes Z_ZERO/Z_PCIN/Z_P/Z_C.
  - opmode bit indices OPM_SUB=7, OPM_CIN=5.
- The four registers reuse the team's shared parameterised pipeline-register cell with RSTTYPE="sync".
- One natural sub-module: dsp_xz_mux (combinational X/Z selection), instanced once.

## Test plan
- Plain add, all REG=1: opmode=8'b0000_1101 (X=m, Z=c), m=100, c=5 → p=105, carryout=0 two cycles after opmode presentation.
- MAC: opmode X=m, Z=P, m=3 for 4 cycles after rst → p=3,6,9,12 on successive edges. ce_p low for one cycle → p holds.
- Subtract with carry: opmode[7]=1, opmode[5]=1, Z=c=10, X=m=4 → p=5. With c=0, m=0 → p=48'hFFFF_FFFF_FFFF, carryout=1.
- Wrap: Z=c=48'hFFFF_FFFF_FFFF, X=m=1, add → p=0, carryout=1.
- Reset mid-accumulate: P=12, assert rst with ce_p=1 → next p=0, carryout=0. Release rst, m=3 → p=3.
- CARRYINSEL="CARRYIN", PREG=0, OPMODEREG=0, CARRYINREG=0: X=DAB with d=1, a=0, b=0 → p=2^36 combinationally in the same cycle. Carryin toggles LSB.
